// File: rtl/spi_slave_rx.sv
// rtl/spi_slave_rx.sv - SPI mode-0 slave receiver with pin synchronisers and byte FIFO
module spi_slave_rx #(
    parameter int SYNC_STAGES = 2,
    parameter int DEPTH_LOG2  = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       nCS,
    input  logic       SCK,
    input  logic       MOSI,
    output logic [7:0] rx_data,
    output logic       rx_first,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       overflow,
    input  logic       overflow_clr,
    output logic       partial
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2+1)'(1);
    localparam logic [DEPTH_LOG2:0]   CNT_FULL = (DEPTH_LOG2+1)'(DEPTH);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

    logic [SYNC_STAGES-1:0] ncs_sync, sck_sync, mosi_sync;
    // Tracks which synchroniser stages hold real pin samples rather than reset fill.
    logic [SYNC_STAGES:0]   ncs_vld;
    logic                   ncs_prev, sck_prev;

    logic [7:0]             shift;
    logic [2:0]             bitcnt;
    logic                   first_pending;
    logic                   framing;

    logic [8:0]             mem [DEPTH];
    logic [DEPTH_LOG2-1:0]  wptr, rptr;
    logic [DEPTH_LOG2:0]    count;

    logic ncs_s, sck_s, mosi_s;
    logic cs_fall, cs_rise, sck_rise, byte_done;
    logic pop, push, full;
    logic [2:0] bitcnt_after;
    logic [7:0] byte_val;

    assign ncs_s  = ncs_sync[SYNC_STAGES-1];
    assign sck_s  = sck_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    // A frame only exists after a genuine nCS fall, so a reset taken mid-frame
    // stays deaf until the host deselects and reselects.
    assign cs_fall      = ncs_vld[SYNC_STAGES] & ncs_prev & ~ncs_s;
    assign cs_rise      = framing & ~ncs_prev & ncs_s;
    assign sck_rise     = framing & sck_s & ~sck_prev;
    assign byte_done    = sck_rise & (bitcnt == 3'd7);
    assign byte_val     = {shift[6:0], mosi_s};
    assign bitcnt_after = sck_rise ? bitcnt + 3'd1 : bitcnt;

    assign rx_valid = (count != '0);
    assign full     = (count == CNT_FULL);
    assign pop      = rx_valid & rx_ready;
    assign push     = byte_done & (~full | pop);
    assign rx_data  = rx_valid ? mem[rptr][7:0] : 8'd0;
    assign rx_first = rx_valid & mem[rptr][8];

    always_ff @(posedge clk) begin
        if (reset) begin
            ncs_sync  <= '1;
            sck_sync  <= '0;
            mosi_sync <= '0;
            ncs_vld   <= '0;
            ncs_prev  <= 1'b1;
            sck_prev  <= 1'b0;
        end else begin
            ncs_sync  <= {ncs_sync[SYNC_STAGES-2:0], nCS};
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], SCK};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
            ncs_vld   <= {ncs_vld[SYNC_STAGES-1:0], 1'b1};
            ncs_prev  <= ncs_s;
            sck_prev  <= sck_s;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shift         <= '0;
            bitcnt        <= '0;
            first_pending <= 1'b0;
            framing       <= 1'b0;
            partial       <= 1'b0;
            overflow      <= 1'b0;
            wptr          <= '0;
            rptr          <= '0;
            count         <= '0;
        end else begin
            partial <= 1'b0;
            if (cs_fall) begin
                bitcnt        <= '0;
                first_pending <= 1'b1;
                framing       <= 1'b1;
            end else begin
                if (sck_rise) begin
                    shift  <= byte_val;
                    bitcnt <= bitcnt_after;
                end
                if (byte_done)
                    first_pending <= 1'b0;
                // A final SCK edge seen with the deselect counts before it.
                if (cs_rise) begin
                    framing <= 1'b0;
                    bitcnt  <= '0;
                    if (bitcnt_after != 3'd0)
                        partial <= 1'b1;
                end
            end

            if (byte_done && !push)
                overflow <= 1'b1;
            else if (overflow_clr)
                overflow <= 1'b0;

            if (push)
                wptr <= wptr + PTR_ONE;
            if (pop)
                rptr <= rptr + PTR_ONE;
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wptr] <= {first_pending, byte_val};
    end
endmodule
